alu_result_reg: RTL

- Registered result stage directly downstream of the 4-bit ALU.
- Captures the ALU's 8-bit output on a user load strobe (KEY-driven) and holds it for the LEDR/HEX display.
- Feeds the low nibble of the stored result back as the ALU's B operand in accumulate mode.
- Counts captures and optionally keeps a short history of past results.

---
 rtl/alu_result_reg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_result_reg.sv
// Registered result stage behind the 4-bit ALU: load-strobe capture with release filter,
// accumulate feedback, saturating capture count; optional history under ALU_RESULT_HISTORY_EN.
module alu_result_reg #(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              acc_en,
    input  logic [3:0]        b_in,
    output logic [3:0]        b_sel,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              overflow,
    output logic [CNT_W-1:0]  load_count,
    input  logic [1:0]        hist_idx,
    output logic [DATA_W-1:0] hist_data
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [SW-1:0]     r_settle;
    logic [SW-1:0]     w_settle_next;
    logic              r_load_q;
    logic              w_edge;
    logic              w_capture;
    logic [DATA_W-1:0] r_result;
    logic              r_valid;
    logic [CNT_W-1:0]  r_count;

    assign w_edge = load & ~r_load_q;

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_capture     = 1'b0;
        if (clr) begin
            w_state_next  = IDLE;
            w_settle_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        w_capture     = 1'b1;
                        w_state_next  = WAIT_REL;
                        w_settle_next = '0;
                    end
                end
                WAIT_REL: begin
                    // Re-arm only after SETTLE_CYCLES consecutive low samples of load.
                    if (load) begin
                        w_settle_next = '0;
                    end else if (r_settle == SETTLE_LAST) begin
                        w_state_next  = IDLE;
                        w_settle_next = '0;
                    end else begin
                        w_settle_next = r_settle + 1'b1;
                    end
                end
                default: begin
                    w_state_next  = IDLE;
                    w_settle_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_load_q <= 1'b1;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_settle <= w_settle_next;
            r_load_q <= load;
            if (clr) begin
                r_result <= '0;
                r_valid  <= 1'b0;
                r_count  <= '0;
            end else if (w_capture) begin
                r_result <= alu_out;
                r_valid  <= 1'b1;
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign load_count   = r_count;
    assign overflow     = |r_result[DATA_W-1:4];
    assign b_sel        = acc_en ? r_result[3:0] : b_in;

`ifdef ALU_RESULT_HISTORY_EN
    logic [DATA_W-1:0] r_hist [4];

    // Entry 0 takes the new capture; older entries shift down. clr leaves history alone.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hist
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hist[gi] <= '0;
                end else if (w_capture) begin
                    if (gi == 0) begin
                        r_hist[gi] <= alu_out;
                    end else begin
                        r_hist[gi] <= r_hist[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
        end
    endgenerate

    assign hist_data = r_hist[hist_idx];
`else
    logic w_unused_hist;
    assign w_unused_hist = ^hist_idx;
    assign hist_data     = '0;
`endif

endmodule
